cw310_reg_crypt_seq: RTL and testbench

- Single-clock crypto register front end, successor to the fixed-width AES register block.
- Parametrised text/key widths.
- Adds a sequencer that runs a batch of N chained operations (ciphertext fed back as next plaintext), with a per-operation timeout and a cycle counter.
- Sits between the USB register front end and a crypto core that is clocked on usb_clk.

---
 rtl/cw310_reg_crypt_seq.sv | 246 ++++++++++++++++++++++++
 tb/tb_cw310_reg_crypt_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cw310_reg_crypt_seq.sv
// Register front end and batch sequencer for a usb_clk-domain crypto core.
// Define CRYPT_EXTTRIG_EN to add the synchronised exttrigger_in start source.
module cw310_reg_crypt_seq #(
   parameter int pADDR_WIDTH          = 21,
   parameter int pBYTECNT_SIZE        = 7,
   parameter int pTEXT_WIDTH          = 128,
   parameter int pKEY_WIDTH           = 128,
   parameter int pBATCH_WIDTH         = 16,
   parameter int pTIMEOUT_WIDTH       = 24,
   parameter int pDONE_EDGE_SENSITIVE = 1
) (
   input  logic                                   usb_clk,
   input  logic                                   reset_i,
   input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0]   reg_address,
   input  logic [pBYTECNT_SIZE-1:0]               reg_bytecnt,
   output logic [7:0]                             read_data,
   input  logic [7:0]                             write_data,
   input  logic                                   reg_read,
   input  logic                                   reg_write,
   input  logic                                   reg_addrvalid,
   input  logic                                   I_ready,
   input  logic                                   I_done,
   input  logic [pTEXT_WIDTH-1:0]                 I_cipherout,
   output logic [pKEY_WIDTH-1:0]                  O_key,
   output logic [pTEXT_WIDTH-1:0]                 O_textin,
   output logic                                   O_start,
   output logic                                   O_busy
`ifdef CRYPT_EXTTRIG_EN
   ,
   input  logic                                   exttrigger_in
`endif
);

   localparam int ADDR_W        = pADDR_WIDTH - pBYTECNT_SIZE;
   localparam int KEY_BYTES     = pKEY_WIDTH / 8;
   localparam int TEXT_BYTES    = pTEXT_WIDTH / 8;
   localparam int BATCH_BYTES   = pBATCH_WIDTH / 8;
   localparam int TIMEOUT_BYTES = pTIMEOUT_WIDTH / 8;

   localparam logic [ADDR_W-1:0] ADDR_KEY      = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] ADDR_TEXTIN   = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_TEXTOUT  = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] ADDR_GO       = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] ADDR_BATCH    = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] ADDR_PROGRESS = ADDR_W'(5);
   localparam logic [ADDR_W-1:0] ADDR_TIMEOUT  = ADDR_W'(6);
   localparam logic [ADDR_W-1:0] ADDR_LASTCYC  = ADDR_W'(7);
   localparam logic [ADDR_W-1:0] ADDR_ABORT    = ADDR_W'(8);

   typedef enum logic [2:0] {IDLE, WAIT_RDY, START, RUN, CAPTURE} state_t;

   state_t                      r_state;
   state_t                      w_nextState;
   logic [pKEY_WIDTH-1:0]       r_key;
   logic [pTEXT_WIDTH-1:0]      r_textin;
   logic [pTEXT_WIDTH-1:0]      r_work;
   logic [pTEXT_WIDTH-1:0]      r_textout;
   logic [pBATCH_WIDTH-1:0]     r_batchCount;
   logic [pBATCH_WIDTH-1:0]     r_progress;
   logic [pTIMEOUT_WIDTH-1:0]   r_timeout;
   logic [pTIMEOUT_WIDTH-1:0]   r_cycles;
   logic [pTIMEOUT_WIDTH-1:0]   r_lastCycles;
   logic                        r_doneFlag;
   logic                        r_timeoutErr;
   logic                        r_donePrev;

   logic                        w_wr;
   logic                        w_byte0;
   logic                        w_regGo;
   logic                        w_extEdge;
   logic                        w_goReq;
   logic                        w_abort;
   logic                        w_doneEvt;
   logic                        w_timeoutHit;
   logic [pBATCH_WIDTH-1:0]     w_effCount;
   logic [pBATCH_WIDTH-1:0]     w_progressInc;
   logic                        w_batchDone;
   logic [pTIMEOUT_WIDTH-1:0]   w_cyclesInc;
   logic [7:0]                  w_readByte;

   assign w_wr          = reg_addrvalid & reg_write;
   assign w_byte0       = (reg_bytecnt == '0);
   assign w_regGo       = w_wr & w_byte0 & (reg_address == ADDR_GO);
   assign w_abort       = w_wr & w_byte0 & (reg_address == ADDR_ABORT);
   assign w_goReq       = w_regGo | w_extEdge;
   assign w_doneEvt     = (pDONE_EDGE_SENSITIVE != 0) ? (I_done & ~r_donePrev) : I_done;
   assign w_timeoutHit  = (r_timeout != '0) && (r_cycles == (r_timeout - pTIMEOUT_WIDTH'(1)));
   assign w_effCount    = (r_batchCount == '0) ? pBATCH_WIDTH'(1) : r_batchCount;
   assign w_progressInc = r_progress + pBATCH_WIDTH'(1);
   assign w_batchDone   = (w_progressInc == w_effCount);
   assign w_cyclesInc   = (r_cycles == '1) ? r_cycles : r_cycles + pTIMEOUT_WIDTH'(1);

   assign O_key    = r_key;
   assign O_textin = r_work;

`ifdef CRYPT_EXTTRIG_EN
   // Two-flop synchroniser, then rising-edge detect so a held trigger starts once.
   (* ASYNC_REG = "TRUE" *) logic r_trigMeta;
   (* ASYNC_REG = "TRUE" *) logic r_trigSync;
   logic r_trigPrev;

   always_ff @(posedge usb_clk or posedge reset_i) begin
      if (reset_i) begin
         r_trigMeta <= 1'b0;
         r_trigSync <= 1'b0;
         r_trigPrev <= 1'b0;
      end else begin
         r_trigMeta <= exttrigger_in;
         r_trigSync <= r_trigMeta;
         r_trigPrev <= r_trigSync;
      end
   end

   assign w_extEdge = r_trigSync & ~r_trigPrev;
`else
   assign w_extEdge = 1'b0;
`endif

   always_ff @(posedge usb_clk or posedge reset_i) begin
      if (reset_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      O_start     = 1'b0;
      O_busy      = (r_state != IDLE);
      case (r_state)
         IDLE:     if (w_goReq) w_nextState = WAIT_RDY;
         WAIT_RDY: if (I_ready) w_nextState = START;
         START: begin
            O_start     = 1'b1;
            w_nextState = RUN;
         end
         RUN: begin
            if (w_doneEvt)         w_nextState = CAPTURE;
            else if (w_timeoutHit) w_nextState = IDLE;
         end
         CAPTURE:  w_nextState = w_batchDone ? IDLE : WAIT_RDY;
         default:  w_nextState = IDLE;
      endcase
      if (w_abort) w_nextState = IDLE;
   end

   // Configuration registers are frozen while a batch is in flight.
   always_ff @(posedge usb_clk or posedge reset_i) begin
      if (reset_i) begin
         r_key        <= '0;
         r_textin     <= '0;
         r_batchCount <= pBATCH_WIDTH'(1);
         r_timeout    <= '0;
      end else if (w_wr && !O_busy) begin
         for (int i = 0; i < KEY_BYTES; i++)
            if (reg_address == ADDR_KEY && reg_bytecnt == pBYTECNT_SIZE'(i))
               r_key[8*i +: 8] <= write_data;
         for (int i = 0; i < TEXT_BYTES; i++)
            if (reg_address == ADDR_TEXTIN && reg_bytecnt == pBYTECNT_SIZE'(i))
               r_textin[8*i +: 8] <= write_data;
         for (int i = 0; i < BATCH_BYTES; i++)
            if (reg_address == ADDR_BATCH && reg_bytecnt == pBYTECNT_SIZE'(i))
               r_batchCount[8*i +: 8] <= write_data;
         for (int i = 0; i < TIMEOUT_BYTES; i++)
            if (reg_address == ADDR_TIMEOUT && reg_bytecnt == pBYTECNT_SIZE'(i))
               r_timeout[8*i +: 8] <= write_data;
      end
   end

   // An abort freezes every sequencer register; only the state returns to IDLE.
   always_ff @(posedge usb_clk or posedge reset_i) begin
      if (reset_i) begin
         r_work       <= '0;
         r_textout    <= '0;
         r_progress   <= '0;
         r_cycles     <= '0;
         r_lastCycles <= '0;
         r_doneFlag   <= 1'b0;
         r_timeoutErr <= 1'b0;
         r_donePrev   <= 1'b0;
      end else begin
         r_donePrev <= I_done;
         if (!w_abort) begin
            case (r_state)
               IDLE: begin
                  if (w_goReq) begin
                     r_work       <= r_textin;
                     r_progress   <= '0;
                     r_doneFlag   <= 1'b0;
                     r_timeoutErr <= 1'b0;
                  end
               end
               START: r_cycles <= '0;
               RUN: begin
                  if (!w_doneEvt) begin
                     if (w_timeoutHit) r_timeoutErr <= 1'b1;
                     else              r_cycles     <= w_cyclesInc;
                  end
               end
               CAPTURE: begin
                  r_textout    <= I_cipherout;
                  r_work       <= I_cipherout;
                  r_lastCycles <= w_cyclesInc;
                  r_progress   <= w_progressInc;
                  if (w_batchDone) r_doneFlag <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      w_readByte = 8'h00;
      case (reg_address)
         ADDR_KEY:
            for (int i = 0; i < KEY_BYTES; i++)
               if (reg_bytecnt == pBYTECNT_SIZE'(i)) w_readByte = r_key[8*i +: 8];
         ADDR_TEXTIN:
            for (int i = 0; i < TEXT_BYTES; i++)
               if (reg_bytecnt == pBYTECNT_SIZE'(i)) w_readByte = r_textin[8*i +: 8];
         ADDR_TEXTOUT:
            for (int i = 0; i < TEXT_BYTES; i++)
               if (reg_bytecnt == pBYTECNT_SIZE'(i)) w_readByte = r_textout[8*i +: 8];
         ADDR_GO:
            if (w_byte0) w_readByte = {5'b0, r_timeoutErr, r_doneFlag, O_busy};
         ADDR_BATCH:
            for (int i = 0; i < BATCH_BYTES; i++)
               if (reg_bytecnt == pBYTECNT_SIZE'(i)) w_readByte = r_batchCount[8*i +: 8];
         ADDR_PROGRESS:
            for (int i = 0; i < BATCH_BYTES; i++)
               if (reg_bytecnt == pBYTECNT_SIZE'(i)) w_readByte = r_progress[8*i +: 8];
         ADDR_TIMEOUT:
            for (int i = 0; i < TIMEOUT_BYTES; i++)
               if (reg_bytecnt == pBYTECNT_SIZE'(i)) w_readByte = r_timeout[8*i +: 8];
         ADDR_LASTCYC:
            for (int i = 0; i < TIMEOUT_BYTES; i++)
               if (reg_bytecnt == pBYTECNT_SIZE'(i)) w_readByte = r_lastCycles[8*i +: 8];
         default: w_readByte = 8'h00;
      endcase
   end

   assign read_data = reg_read ? w_readByte : 8'h00;

endmodule

// File: tb/tb_cw310_reg_crypt_seq.sv
// Directed bench for cw310_reg_crypt_seq with a behavioural crypto core model.
`timescale 1ns/1ps
module tb_cw310_reg_crypt_seq;

   localparam int AW = 14;
   localparam int BW = 7;

   localparam logic [AW-1:0] A_KEY      = 14'h0;
   localparam logic [AW-1:0] A_TEXTIN   = 14'h1;
   localparam logic [AW-1:0] A_TEXTOUT  = 14'h2;
   localparam logic [AW-1:0] A_GO       = 14'h3;
   localparam logic [AW-1:0] A_BATCH    = 14'h4;
   localparam logic [AW-1:0] A_PROGRESS = 14'h5;
   localparam logic [AW-1:0] A_TIMEOUT  = 14'h6;
   localparam logic [AW-1:0] A_LASTCYC  = 14'h7;
   localparam logic [AW-1:0] A_ABORT    = 14'h8;
   localparam logic [AW-1:0] A_UNMAPPED = 14'h9;

   logic           usb_clk = 1'b0;
   logic           reset_i;
   logic [AW-1:0]  reg_address;
   logic [BW-1:0]  reg_bytecnt;
   logic [7:0]     read_data;
   logic [7:0]     write_data;
   logic           reg_read;
   logic           reg_write;
   logic           reg_addrvalid;
   logic           I_ready;
   logic           I_done;
   logic [127:0]   I_cipherout;
   logic [127:0]   O_key;
   logic [127:0]   O_textin;
   logic           O_start;
   logic           O_busy;
`ifdef CRYPT_EXTTRIG_EN
   logic           exttrigger_in = 1'b0;
`endif

   int checks    = 0;
   int failures  = 0;
   int startCount = 0;
   int modelLatency = 10;
   bit modelNeverDone = 1'b0;

   cw310_reg_crypt_seq dut (
      .usb_clk       (usb_clk),
      .reset_i       (reset_i),
      .reg_address   (reg_address),
      .reg_bytecnt   (reg_bytecnt),
      .read_data     (read_data),
      .write_data    (write_data),
      .reg_read      (reg_read),
      .reg_write     (reg_write),
      .reg_addrvalid (reg_addrvalid),
      .I_ready       (I_ready),
      .I_done        (I_done),
      .I_cipherout   (I_cipherout),
      .O_key         (O_key),
      .O_textin      (O_textin),
      .O_start       (O_start),
      .O_busy        (O_busy)
`ifdef CRYPT_EXTTRIG_EN
      ,
      .exttrigger_in (exttrigger_in)
`endif
   );

   always #5 usb_clk = ~usb_clk;

   function automatic logic [127:0] cipherModel(input logic [127:0] t, input logic [127:0] k);
      return {t[119:0], t[127:120]} ^ k ^ 128'h0123_4567_89ab_cdef_0f1e_2d3c_4b5a_6978;
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Core model: result computed at start, done raised modelLatency cycles after the start-sampling edge.
   initial begin
      int cnt;
      cnt = 0;
      I_done = 1'b0;
      I_cipherout = '0;
      forever begin
         @(posedge usb_clk);
         #1;
         if (O_start) begin
            startCount++;
            I_done = 1'b0;
            I_cipherout = cipherModel(O_textin, O_key);
            cnt = modelNeverDone ? 0 : modelLatency + 1;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) I_done = 1'b1;
         end
      end
   end

   task automatic writeByte(input logic [AW-1:0] addr, input int idx, input logic [7:0] data);
      @(negedge usb_clk);
      reg_address   = addr;
      reg_bytecnt   = BW'(idx);
      write_data    = data;
      reg_addrvalid = 1'b1;
      reg_write     = 1'b1;
      @(negedge usb_clk);
      reg_write     = 1'b0;
      reg_addrvalid = 1'b0;
   endtask

   task automatic applyStimulus(input logic [AW-1:0] addr, input logic [127:0] value, input int nbytes);
      for (int i = 0; i < nbytes; i++) writeByte(addr, i, value[8*i +: 8]);
   endtask

   task automatic readByte(input logic [AW-1:0] addr, input int idx, output logic [7:0] data);
      @(negedge usb_clk);
      reg_address = addr;
      reg_bytecnt = BW'(idx);
      reg_read    = 1'b1;
      #1;
      data = read_data;
      reg_read = 1'b0;
   endtask

   task automatic checkReg(input string tag, input logic [AW-1:0] addr, input int nbytes, input logic [127:0] expected);
      logic [127:0] value;
      logic [7:0]   b;
      value = '0;
      for (int i = 0; i < nbytes; i++) begin
         readByte(addr, i, b);
         value[8*i +: 8] = b;
      end
      checkOutput(tag, value, expected);
   endtask

   task automatic waitIdle(input string tag, input int maxCycles);
      int n;
      n = 0;
      while (O_busy && n < maxCycles) begin
         @(negedge usb_clk);
         n++;
      end
      checkOutput(tag, {127'b0, O_busy}, 128'd0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [127:0] key;
      logic [127:0] pt;
      logic [127:0] q;
      logic [127:0] f3;
      logic [7:0]   b;
      int           n;

      key = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
      pt  = 128'h3243f6a8_885a308d_313198a2_e0370734;
      q   = 128'hdeadbeef_00112233_44556677_8899aabb;

      reset_i       = 1'b1;
      reg_address   = '0;
      reg_bytecnt   = '0;
      write_data    = '0;
      reg_read      = 1'b0;
      reg_write     = 1'b0;
      reg_addrvalid = 1'b0;
      I_ready       = 1'b1;
      repeat (3) @(negedge usb_clk);
      reset_i = 1'b0;

      $display("[TB] reset values");
      checkOutput("rst_busy",   {127'b0, O_busy}, 128'd0);
      checkOutput("rst_start",  {127'b0, O_start}, 128'd0);
      checkOutput("rst_okey",   O_key, 128'd0);
      checkOutput("rst_otext",  O_textin, 128'd0);
      checkReg("rst_key",      A_KEY, 16, 128'd0);
      checkReg("rst_textin",   A_TEXTIN, 16, 128'd0);
      checkReg("rst_textout",  A_TEXTOUT, 16, 128'd0);
      checkReg("rst_status",   A_GO, 1, 128'h00);
      checkReg("rst_batch",    A_BATCH, 2, 128'd1);
      checkReg("rst_progress", A_PROGRESS, 2, 128'd0);
      checkReg("rst_timeout",  A_TIMEOUT, 3, 128'd0);
      checkReg("rst_lastcyc",  A_LASTCYC, 3, 128'd0);
      checkReg("rst_unmapped", A_UNMAPPED, 1, 128'd0);

      $display("[TB] single operation");
      applyStimulus(A_KEY, key, 16);
      applyStimulus(A_TEXTIN, pt, 16);
      applyStimulus(A_BATCH, 128'd1, 2);
      checkOutput("key_out", O_key, key);
      startCount   = 0;
      modelLatency = 10;
      applyStimulus(A_GO, 128'd1, 1);
      checkOutput("go_lat_early", {127'b0, O_start}, 128'd0);
      @(negedge usb_clk);
      checkOutput("go_lat_start", {127'b0, O_start}, 128'd1);
      waitIdle("single_idle", 100);
      checkOutput("single_starts", 128'(startCount), 128'd1);
      checkReg("single_textout", A_TEXTOUT, 16, cipherModel(pt, key));
      checkReg("single_lastcyc", A_LASTCYC, 3, 128'd11);
      checkReg("single_status",  A_GO, 1, 128'h02);
      checkReg("single_progress", A_PROGRESS, 2, 128'd1);

      $display("[TB] chained batch of three");
      applyStimulus(A_BATCH, 128'd3, 2);
      startCount   = 0;
      modelLatency = 4;
      applyStimulus(A_GO, 128'd1, 1);
      waitIdle("batch_idle", 200);
      f3 = cipherModel(cipherModel(cipherModel(pt, key), key), key);
      checkOutput("batch_starts", 128'(startCount), 128'd3);
      checkReg("batch_textout", A_TEXTOUT, 16, f3);
      checkOutput("batch_otext", O_textin, f3);
      checkReg("batch_progress", A_PROGRESS, 2, 128'd3);
      checkReg("batch_status", A_GO, 1, 128'h02);

      $display("[TB] timeout");
      applyStimulus(A_TIMEOUT, 128'd5, 3);
      applyStimulus(A_BATCH, 128'd1, 2);
      modelNeverDone = 1'b1;
      startCount     = 0;
      applyStimulus(A_GO, 128'd1, 1);
      n = 0;
      while (!O_start && n < 10) begin
         @(negedge usb_clk);
         n++;
      end
      checkOutput("tmo_start_seen", {127'b0, O_start}, 128'd1);
      n = 0;
      while (O_busy && n < 50) begin
         @(negedge usb_clk);
         n++;
      end
      checkOutput("tmo_busy_cycles", 128'(n), 128'd6);
      checkReg("tmo_status", A_GO, 1, 128'h04);
      checkReg("tmo_progress", A_PROGRESS, 2, 128'd0);
      checkOutput("tmo_starts", 128'(startCount), 128'd1);
      applyStimulus(A_TIMEOUT, 128'd0, 3);

      $display("[TB] writes while busy, then abort");
      startCount = 0;
      applyStimulus(A_GO, 128'd1, 1);
      repeat (4) @(negedge usb_clk);
      applyStimulus(A_TEXTIN, q, 16);
      applyStimulus(A_GO, 128'd1, 1);
      repeat (4) @(negedge usb_clk);
      checkOutput("busy_otext", O_textin, pt);
      checkOutput("busy_starts", 128'(startCount), 128'd1);
      checkReg("busy_textin_reg", A_TEXTIN, 16, pt);
      checkOutput("busy_before_abort", {127'b0, O_busy}, 128'd1);
      applyStimulus(A_ABORT, 128'h5a, 1);
      checkOutput("abort_busy", {127'b0, O_busy}, 128'd0);
      checkOutput("abort_start", {127'b0, O_start}, 128'd0);
      checkReg("abort_status", A_GO, 1, 128'h00);
      checkReg("abort_progress", A_PROGRESS, 2, 128'd0);

      $display("[TB] batch count zero and byte-index boundaries");
      modelNeverDone = 1'b0;
      modelLatency   = 3;
      applyStimulus(A_BATCH, 128'd0, 2);
      startCount = 0;
      applyStimulus(A_GO, 128'd1, 1);
      waitIdle("zero_idle", 100);
      checkOutput("zero_starts", 128'(startCount), 128'd1);
      checkReg("zero_progress", A_PROGRESS, 2, 128'd1);
      checkReg("zero_status", A_GO, 1, 128'h02);
      checkReg("zero_batch_reg", A_BATCH, 2, 128'd0);
      writeByte(A_KEY, 16, 8'hff);
      readByte(A_KEY, 16, b);
      checkOutput("key_byte16", {120'b0, b}, 128'd0);
      checkReg("key_intact", A_KEY, 16, key);
      readByte(A_BATCH, 2, b);
      checkOutput("batch_byte2", {120'b0, b}, 128'd0);
      readByte(A_GO, 1, b);
      checkOutput("status_byte1", {120'b0, b}, 128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
